// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch predictor: direction-counter encodings and the BTB entry layout.
package branch_predict_unit_pkg;

  localparam int unsigned DEFAULT_INDEX_BITS = 6;
  // Tag field sized for the smallest legal index; narrower tags are zero-extended into it.
  localparam int unsigned MAX_TAG_BITS = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } counterT;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    counterT                 ctr;
  } btbEntryT;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  counterT Cur,
  input  logic    Up,
  output counterT Next
);

  always_comb begin
    Next = Cur;
    unique case (Cur)
      SNT: Next = Up ? WNT : SNT;
      WNT: Next = Up ? WT  : SNT;
      WT:  Next = Up ? ST  : WNT;
      ST:  Next = Up ? ST  : WT;
      default: Next = Cur;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch lookup, resolve-side
// mispredict detection and redirect, table training and performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] FetchPC,
  output logic        PredictTaken,
  output logic [31:0] PredictTarget,
  input  logic        ResolveValid,
  input  logic [31:0] ResolvePC,
  input  logic        CompareResult,
  input  logic [31:0] ResolveTarget,
  input  logic        ResolvePredTaken,
  input  logic [31:0] ResolvePredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int Entries = 1 << INDEX_BITS;

  btbEntryT btbQ [Entries];

  logic [INDEX_BITS-1:0]   fetchIdx, resolveIdx;
  logic [MAX_TAG_BITS-1:0] fetchTag, resolveTag;
  btbEntryT                fetchEntry, resolveEntry;
  logic                    fetchHit, resolveHit;
  counterT                 ctrNext;
  logic                    unusedPcBits;

  assign unusedPcBits = ^{FetchPC[1:0], ResolvePC[1:0]};

  assign fetchIdx   = FetchPC[INDEX_BITS+1:2];
  assign fetchTag   = MAX_TAG_BITS'(FetchPC[31 -: TAG_BITS]);
  assign resolveIdx = ResolvePC[INDEX_BITS+1:2];
  assign resolveTag = MAX_TAG_BITS'(ResolvePC[31 -: TAG_BITS]);

  assign fetchEntry   = btbQ[fetchIdx];
  assign resolveEntry = btbQ[resolveIdx];
  assign fetchHit     = fetchEntry.valid && (fetchEntry.tag == fetchTag);
  assign resolveHit   = resolveEntry.valid && (resolveEntry.tag == resolveTag);

  // Fetch reads stored state only, so a same-cycle update is seen next cycle.
  always_comb begin
    PredictTaken  = 1'b0;
    PredictTarget = '0;
    if (!Reset && fetchHit && fetchEntry.ctr[1]) begin
      PredictTaken  = 1'b1;
      PredictTarget = fetchEntry.target;
    end
  end

  always_comb begin
    Mispredict = 1'b0;
    RedirectPC = '0;
    if (!Reset && ResolveValid) begin
      Mispredict = (CompareResult != ResolvePredTaken) ||
                   (CompareResult && ResolvePredTaken && (ResolveTarget != ResolvePredTarget));
    end
    if (Mispredict) begin
      RedirectPC = CompareResult ? ResolveTarget : ResolvePC + 32'd4;
    end
  end

  sat_counter2 resolveCtr (
    .Cur  (resolveEntry.ctr),
    .Up   (CompareResult),
    .Next (ctrNext)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < Entries; i++) begin
        btbQ[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (ResolveValid) begin
      BranchCount <= BranchCount + 32'd1;
      if (Mispredict) begin
        MispredictCount <= MispredictCount + 32'd1;
      end
      if (resolveHit) begin
        btbQ[resolveIdx].ctr <= ctrNext;
        if (CompareResult) begin
          btbQ[resolveIdx].target <= ResolveTarget;
        end
      end else if (CompareResult) begin
        btbQ[resolveIdx] <= '{valid: 1'b1, tag: resolveTag, target: ResolveTarget, ctr: WT};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
module tb_branch_predict_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] FetchPC;
  logic        PredictTaken;
  logic [31:0] PredictTarget;
  logic        ResolveValid;
  logic [31:0] ResolvePC;
  logic        CompareResult;
  logic [31:0] ResolveTarget;
  logic        ResolvePredTaken;
  logic [31:0] ResolvePredTarget;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int checks = 0;
  int errors = 0;

  branch_predict_unit dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .FetchPC           (FetchPC),
    .PredictTaken      (PredictTaken),
    .PredictTarget     (PredictTarget),
    .ResolveValid      (ResolveValid),
    .ResolvePC         (ResolvePC),
    .CompareResult     (CompareResult),
    .ResolveTarget     (ResolveTarget),
    .ResolvePredTaken  (ResolvePredTaken),
    .ResolvePredTarget (ResolvePredTarget),
    .Mispredict        (Mispredict),
    .RedirectPC        (RedirectPC),
    .BranchCount       (BranchCount),
    .MispredictCount   (MispredictCount)
  );

  always #5 Clk = ~Clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled off-edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic predTaken, input logic [31:0] predTgt);
    ResolveValid      = 1'b1;
    ResolvePC         = pc;
    CompareResult     = taken;
    ResolveTarget     = tgt;
    ResolvePredTaken  = predTaken;
    ResolvePredTarget = predTgt;
    #1;
  endtask

  task automatic idle();
    ResolveValid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    FetchPC = 32'h0040_0010;
    ResolveValid = 1'b0; ResolvePC = '0; CompareResult = 1'b0; ResolveTarget = '0;
    ResolvePredTaken = 1'b0; ResolvePredTarget = '0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (PredictTaken !== 1'b0 || PredictTarget !== 32'h0) begin
      errors++;
      $display("FAIL reset_lookup: taken=%b target=%h, want 0/0", PredictTaken, PredictTarget);
    end
    checks++;
    if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: %0d/%0d, want 0/0", BranchCount, MispredictCount);
    end
  endtask

  task automatic test_allocate();
    resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
    checks++;
    if (Mispredict !== 1'b1 || RedirectPC !== 32'h0040_0040) begin
      errors++;
      $display("FAIL alloc_mispredict: mp=%b redirect=%h, want 1/00400040", Mispredict, RedirectPC);
    end
    tick(); idle();
    checks++;
    if (PredictTaken !== 1'b1 || PredictTarget !== 32'h0040_0040) begin
      errors++;
      $display("FAIL alloc_lookup: taken=%b target=%h, want 1/00400040", PredictTaken, PredictTarget);
    end
    checks++;
    if (BranchCount !== 32'd1 || MispredictCount !== 32'd1) begin
      errors++;
      $display("FAIL alloc_counts: %0d/%0d, want 1/1", BranchCount, MispredictCount);
    end
  endtask

  task automatic test_counter();
    logic [5:0] expTaken;
    logic [5:0] expMp;
    logic [5:0] predT;
    logic [5:0] dir;
    expTaken = 6'b001111;  // bit i = PredictTaken after resolve i
    expMp    = 6'b011000;
    predT    = 6'b011111;
    dir      = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      resolve(32'h0040_0010, dir[i], 32'h0040_0040, predT[i], 32'h0040_0040);
      checks++;
      if (Mispredict !== expMp[i]) begin
        errors++;
        $display("FAIL ctr_mispredict[%0d]: got %b want %b", i, Mispredict, expMp[i]);
      end
      if (i == 3) begin
        checks++;
        if (RedirectPC !== 32'h0040_0014) begin
          errors++;
          $display("FAIL ctr_redirect: got %h want 00400014", RedirectPC);
        end
      end
      tick(); idle();
      checks++;
      if (PredictTaken !== expTaken[i]) begin
        errors++;
        $display("FAIL ctr_taken[%0d]: got %b want %b", i, PredictTaken, expTaken[i]);
      end
    end
    checks++;
    if (BranchCount !== 32'd7 || MispredictCount !== 32'd3) begin
      errors++;
      $display("FAIL ctr_counts: %0d/%0d, want 7/3", BranchCount, MispredictCount);
    end
  endtask

  task automatic test_alias();
    resolve(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    tick(); idle();
    checks++;
    if (PredictTaken !== 1'b0 || PredictTarget !== 32'h0) begin
      errors++;
      $display("FAIL alias_old: taken=%b target=%h, want 0/0", PredictTaken, PredictTarget);
    end
    FetchPC = 32'h0040_0110;
    #1;
    checks++;
    if (PredictTaken !== 1'b1 || PredictTarget !== 32'h0040_0200) begin
      errors++;
      $display("FAIL alias_new: taken=%b target=%h, want 1/00400200", PredictTaken, PredictTarget);
    end
    FetchPC = 32'h0040_0010;
  endtask

  task automatic test_target_mismatch();
    resolve(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
    tick();
    resolve(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040);
    checks++;
    if (Mispredict !== 1'b1 || RedirectPC !== 32'h0040_0080) begin
      errors++;
      $display("FAIL tgt_mispredict: mp=%b redirect=%h, want 1/00400080", Mispredict, RedirectPC);
    end
    tick(); idle();
    checks++;
    if (PredictTaken !== 1'b1 || PredictTarget !== 32'h0040_0080) begin
      errors++;
      $display("FAIL tgt_update: taken=%b target=%h, want 1/00400080", PredictTaken, PredictTarget);
    end
    checks++;
    if (BranchCount !== 32'd10 || MispredictCount !== 32'd6) begin
      errors++;
      $display("FAIL tgt_counts: %0d/%0d, want 10/6", BranchCount, MispredictCount);
    end
  endtask

  task automatic test_not_taken_miss();
    resolve(32'h0040_0020, 1'b0, 32'h0040_0999, 1'b0, 32'h0);
    checks++;
    if (Mispredict !== 1'b0 || RedirectPC !== 32'h0) begin
      errors++;
      $display("FAIL ntmiss_mp: mp=%b redirect=%h, want 0/0", Mispredict, RedirectPC);
    end
    tick(); idle();
    FetchPC = 32'h0040_0020;
    #1;
    checks++;
    if (PredictTaken !== 1'b0 || BranchCount !== 32'd11 || MispredictCount !== 32'd6) begin
      errors++;
      $display("FAIL ntmiss_state: taken=%b counts %0d/%0d, want 0 11/6",
               PredictTaken, BranchCount, MispredictCount);
    end
    FetchPC = 32'h0040_0010;
  endtask

  task automatic test_same_cycle();
    FetchPC = 32'h0040_0010;
    resolve(32'h0040_0110, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    checks++;
    if (PredictTaken !== 1'b1 || PredictTarget !== 32'h0040_0080) begin
      errors++;
      $display("FAIL same_cycle_old: taken=%b target=%h, want 1/00400080",
               PredictTaken, PredictTarget);
    end
    tick(); idle();
    checks++;
    if (PredictTaken !== 1'b0 || BranchCount !== 32'd12 || MispredictCount !== 32'd7) begin
      errors++;
      $display("FAIL same_cycle_new: taken=%b counts %0d/%0d, want 0 12/7",
               PredictTaken, BranchCount, MispredictCount);
    end
  endtask

  task automatic test_redirect_wrap();
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    checks++;
    if (Mispredict !== 1'b1 || RedirectPC !== 32'h0) begin
      errors++;
      $display("FAIL wrap_redirect: mp=%b redirect=%h, want 1/00000000", Mispredict, RedirectPC);
    end
    tick();
    // ResolveValid low: other resolve inputs must be ignored
    ResolveValid = 1'b0; CompareResult = 1'b1; ResolvePredTaken = 1'b0;
    #1;
    checks++;
    if (Mispredict !== 1'b0 || RedirectPC !== 32'h0) begin
      errors++;
      $display("FAIL invalid_ignored: mp=%b redirect=%h, want 0/0", Mispredict, RedirectPC);
    end
    tick();
    checks++;
    if (BranchCount !== 32'd13 || MispredictCount !== 32'd8) begin
      errors++;
      $display("FAIL wrap_counts: %0d/%0d, want 13/8", BranchCount, MispredictCount);
    end
  endtask

  task automatic test_reset_resolve();
    Reset = 1'b1;
    FetchPC = 32'h0040_0110;
    resolve(32'h0040_0050, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
    checks++;
    if (Mispredict !== 1'b0 || RedirectPC !== 32'h0 || PredictTaken !== 1'b0 ||
        PredictTarget !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: mp=%b redirect=%h taken=%b target=%h, want all 0",
               Mispredict, RedirectPC, PredictTaken, PredictTarget);
    end
    tick();
    Reset = 1'b0;
    idle();
    checks++;
    if (BranchCount !== 32'd0 || MispredictCount !== 32'd0 || PredictTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_cleared: counts %0d/%0d taken=%b, want 0/0 0",
               BranchCount, MispredictCount, PredictTaken);
    end
    FetchPC = 32'h0040_0050;
    #1;
    checks++;
    if (PredictTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_alloc: taken=%b want 0", PredictTaken);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_target_mismatch();
    test_not_taken_miss();
    test_same_cycle();
    test_redirect_wrap();
    test_reset_resolve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters for the MIPS32 core.
- Fetch side: combinational predicted-taken and target lookup for the current fetch PC.
- Resolve side: consumes the branch compare result from the decode-stage compare logic, detects mispredictions, drives redirect/flush and trains the table on the clock edge.
- Keeps 32-bit branch and mispredict performance counters.

Parameters:
- INDEX_BITS, 6, log2 of entry count (64 entries); index = PC[INDEX_BITS+1:2]
- TAG_BITS, 32-INDEX_BITS-2, tag = PC[31:INDEX_BITS+2]

Ports:
- Clk  in  1  core clock, rising edge
- Reset  in  1  synchronous, active-high
- FetchPC  in  32  PC being fetched this cycle
- PredictTaken  out  1  1 = fetch should use PredictTarget
- PredictTarget  out  32  predicted target (0 when PredictTaken=0)
- ResolveValid  in  1  a branch resolves this cycle
- ResolvePC  in  32  PC of the resolving branch
- CompareResult  in  1  actual direction from the compare logic (1 = taken)
- ResolveTarget  in  32  computed branch target
- ResolvePredTaken  in  1  prediction carried down the pipe with this branch
- ResolvePredTarget  in  32  predicted target carried with this branch
- Mispredict  out  1  combinational, same cycle as ResolveValid
- RedirectPC  out  32  correct next PC when Mispredict=1, else 0
- BranchCount  out  32  resolved branches since reset
- MispredictCount  out  32  mispredictions since reset

Behaviour:
- Entry = {valid, tag[TAG_BITS], target[32], ctr[2]}. Reset clears every valid bit to 0, ctr to 2'b01, and both counters to 0. While Reset=1: PredictTaken=0, PredictTarget=0, Mispredict=0, RedirectPC=0, and no table update.
- Lookup is combinational from the stored state. Hit = valid && tag match. PredictTaken = hit && ctr[1]. PredictTarget = target when PredictTaken, else 0.
- Mispredict = ResolveValid && ((CompareResult != ResolvePredTaken) || (CompareResult && ResolvePredTaken && ResolveTarget != ResolvePredTarget)).
- RedirectPC when Mispredict: CompareResult ? ResolveTarget : ResolvePC+4 (32-bit wrap). Otherwise 0.
- Training happens at the rising edge when ResolveValid=1 and Reset=0. The resolve index is looked up independently of the fetch port.
  - hit, taken: ctr saturating-increment (max 2'b11); target <= ResolveTarget.
  - hit, not taken: ctr saturating-decrement (min 2'b00); target unchanged.
  - miss, taken: allocate (overwrite any occupant) with valid=1, tag, target=ResolveTarget, ctr=2'b10.
  - miss, not taken: no change.
- Counters, each wrapping at 2^32:
  - BranchCount increments on every trained resolve.
  - MispredictCount increments when Mispredict=1 on that edge.
- Same cycle, same index on fetch and resolve: the fetch sees the pre-update entry (no bypass). The update becomes visible the following cycle.
- Reset asserted in the same cycle as ResolveValid: reset wins and nothing is trained or counted.
- ResolveValid=0: all resolve inputs are ignored and no state changes.
- FetchPC[1:0] and ResolvePC[1:0] are ignored.

Decomposition:
- Shared package: counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11; the entry struct typedef; the default INDEX_BITS.
- One natural sub-module: sat_counter2 (2-bit saturating up/down next-state function). Instantiate it once on the resolve path.

Test Plan:
- After reset, FetchPC=0x00400010 → PredictTaken=0, PredictTarget=0; BranchCount=0, MispredictCount=0.
- Resolve PC=0x00400010, taken, target 0x00400040, PredTaken=0 → Mispredict=1, RedirectPC=0x00400040. Next cycle FetchPC=0x00400010 gives PredictTaken=1, PredictTarget=0x00400040; MispredictCount=1.
- Same branch: three more taken resolves, then three not-taken resolves → ctr goes 10→11→11→11→10→01→00. PredictTaken reads 1,1,1,1,0,0 after each. The first not-taken resolve with PredTaken=1 gives Mispredict=1, RedirectPC=0x00400014.
- Alias: PC 0x00400110 (same index, different tag) resolves taken to 0x00400200 → entry replaced. FetchPC=0x00400010 then misses (PredictTaken=0).
- Target mismatch: hit predicted taken to 0x00400040, actual taken to 0x00400080 → Mispredict=1, RedirectPC=0x00400080, and the target is updated.
- Reset held in the same cycle as ResolveValid=1 (taken) → no allocation and BranchCount stays 0. Same-cycle fetch/resolve on one index: the fetch returns the old entry.
